// File: rtl/sampler_stream_ctrl.sv
// -----------------------------------------------------------------------------
// sampler_stream_ctrl
//   Sequences the 3b sample unpacker: holds it in reset, primes the packet FIFO
//   to a fill threshold, releases it, then watches sample_valid for underrun.
//   The FIFO empty flag seen by the sampler is forced high while it is held
//   off, so it cannot pop words before RUN.
//
//   Optional feature macro: AUTO_RESTART_EN
//     defined   : underrun sends RUN -> FLUSH and streaming resumes on its own
//     undefined : underrun sends RUN -> IDLE; the host must issue start again
//
// Ports
//   clk_sample      in   sample clock, all logic on posedge
//   reset           in   asynchronous active-high reset
//   start           in   1-cycle request to begin streaming (honoured in IDLE)
//   stop            in   1-cycle request to halt streaming (any non-IDLE state)
//   clear_stats     in   clears underrun_count (wins over a same-cycle increment)
//   prime_level     in   FIFO words required before releasing the sampler
//   fifo_level      in   packet FIFO occupancy (same clock domain)
//   fifo_empty      in   packet FIFO empty flag
//   sample_valid    in   sampler output valid
//   sampler_reset   out  sampler reset, registered
//   sampler_empty   out  fifo_empty | ~gate, combinational
//   run_active      out  high while in RUN, registered
//   underrun        out  1-cycle registered underrun pulse
//   underrun_count  out  saturating underrun counter
//   state           out  IDLE=0 FLUSH=1 PRIME=2 RUN=3
// -----------------------------------------------------------------------------
module sampler_stream_ctrl #(
    parameter int unsigned LEVEL_WIDTH  = 12,
    parameter int unsigned HOLDOFF      = 4,
    parameter int unsigned FLUSH_CYCLES = 4
) (
    input  logic                   clk_sample,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   clear_stats,
    input  logic [LEVEL_WIDTH-1:0] prime_level,
    input  logic [LEVEL_WIDTH-1:0] fifo_level,
    input  logic                   fifo_empty,
    input  logic                   sample_valid,
    output logic                   sampler_reset,
    output logic                   sampler_empty,
    output logic                   run_active,
    output logic                   underrun,
    output logic [15:0]            underrun_count,
    output logic [1:0]             state
);

    localparam int unsigned COUNT_W = 16;
    // Flush counter walks 0..FLUSH_CYCLES-1; miss counter walks 0..HOLDOFF-1,
    // the HOLDOFF-th miss is detected combinationally and never stored.
    localparam int unsigned FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int unsigned MISS_W  = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);
    localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(HOLDOFF - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_PRIME = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

`ifdef AUTO_RESTART_EN
    localparam state_t UNDERRUN_DEST = ST_FLUSH;
`else
    localparam state_t UNDERRUN_DEST = ST_IDLE;
`endif

    state_t               state_q;
    state_t               state_d;
    logic [FLUSH_W-1:0]   flush_cnt_q;
    logic [FLUSH_W-1:0]   flush_cnt_d;
    logic [MISS_W-1:0]    miss_q;
    logic [MISS_W-1:0]    miss_d;
    logic                 armed_q;
    logic                 armed_d;
    logic                 underrun_hit;
    logic                 sampler_reset_d;
    logic                 run_active_d;
    logic [COUNT_W-1:0]   count_q;

    // State and registered-output flops
    always_ff @(posedge clk_sample or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            flush_cnt_q   <= '0;
            miss_q        <= '0;
            armed_q       <= 1'b0;
            sampler_reset <= 1'b1;
            run_active    <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            miss_q        <= miss_d;
            armed_q       <= armed_d;
            sampler_reset <= sampler_reset_d;
            run_active    <= run_active_d;
            underrun      <= underrun_hit;
        end
    end

    // Next-state, counters and registered-output decode
    always_comb begin
        state_d         = state_q;
        flush_cnt_d     = flush_cnt_q;
        miss_d          = miss_q;
        armed_d         = armed_q;
        underrun_hit    = 1'b0;
        sampler_reset_d = 1'b1;
        run_active_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = ST_PRIME;
                end else begin
                    flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
                end
            end
            ST_PRIME: begin
                if (fifo_level >= prime_level) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Misses only count once the sampler has produced output.
                if (sample_valid) begin
                    armed_d = 1'b1;
                    miss_d  = '0;
                end else if (armed_q) begin
                    if (miss_q == MISS_LAST) begin
                        underrun_hit = 1'b1;
                        state_d      = UNDERRUN_DEST;
                    end else begin
                        miss_d = miss_q + MISS_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // stop overrides everything, including a coincident underrun
        if (stop && (state_q != ST_IDLE)) begin
            state_d      = ST_IDLE;
            underrun_hit = 1'b0;
        end

        // Every RUN entry starts disarmed; every FLUSH entry starts at zero
        if (state_d != ST_RUN) begin
            armed_d = 1'b0;
            miss_d  = '0;
        end
        if (state_d != ST_FLUSH) begin
            flush_cnt_d = '0;
        end

        // Release and gate change on the same edge that enters RUN
        sampler_reset_d = (state_d != ST_RUN);
        run_active_d    = (state_d == ST_RUN);
    end

    // Saturating underrun counter; clear wins over increment
    always_ff @(posedge clk_sample or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear_stats) begin
            count_q <= '0;
        end else if (underrun_hit && (count_q != {COUNT_W{1'b1}})) begin
            count_q <= count_q + COUNT_W'(1);
        end
    end

    // The gate is exactly "in RUN", so run_active doubles as the gate
    assign sampler_empty  = fifo_empty | ~run_active;
    assign underrun_count = count_q;
    assign state          = state_q;

endmodule
